// File: rtl/gshare_predictor_ctrl.sv
// Gshare branch direction predictor: global history XOR PC indexes a table of
// 2-bit saturating counters; the table is swept to weakly-not-taken after reset.
module gshare_predictor_ctrl #(
    parameter int HISTORY_WIDTH   = 4,
    parameter int PHT_INDEX_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetchValid,
    input  logic                     fetchIsBranch,
    input  logic [31:0]              fetchPc,
    output logic                     isBranchTakenPredicted,
    output logic [HISTORY_WIDTH-1:0] globalBranchHistory,
    output logic                     predictorReady,
    input  logic                     resolveValid,
    input  logic [31:0]              resolvePc,
    input  logic [HISTORY_WIDTH-1:0] resolveHistory,
    input  logic                     resolveTaken,
    input  logic                     resolveMispredict
);

    localparam int PHT_DEPTH = 1 << PHT_INDEX_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                       state, state_next;
    logic [PHT_INDEX_WIDTH-1:0]   init_counter, init_counter_next;
    logic [HISTORY_WIDTH-1:0]     spec_ghr, spec_ghr_next;
    logic [1:0]                   pht [PHT_DEPTH];

    logic                         pht_we;
    logic [PHT_INDEX_WIDTH-1:0]   pht_waddr;
    logic [1:0]                   pht_wdata;
    logic [PHT_INDEX_WIDTH-1:0]   fetch_idx;
    logic [PHT_INDEX_WIDTH-1:0]   resolve_idx;
    logic [1:0]                   resolve_cnt;
    logic                         predict;

    logic unused_bits;
    assign unused_bits = ^{fetchPc[31:PHT_INDEX_WIDTH+2], fetchPc[1:0],
                           resolvePc[31:PHT_INDEX_WIDTH+2], resolvePc[1:0],
                           resolveHistory[HISTORY_WIDTH-1]};

    assign fetch_idx   = fetchPc[PHT_INDEX_WIDTH+1:2] ^ spec_ghr;
    assign resolve_idx = resolvePc[PHT_INDEX_WIDTH+1:2] ^ resolveHistory;
    assign resolve_cnt = pht[resolve_idx];

    // Table read is taken before this cycle's write, so a colliding resolve
    // only becomes visible on the following cycle.
    assign predict                = (state == READY) ? pht[fetch_idx][1] : 1'b0;
    assign isBranchTakenPredicted = predict;
    assign globalBranchHistory    = spec_ghr;
    assign predictorReady         = (state == READY);

    always_comb begin
        state_next        = state;
        init_counter_next = init_counter;
        spec_ghr_next     = spec_ghr;
        pht_we            = 1'b0;
        pht_waddr         = init_counter;
        pht_wdata         = 2'b01;
        case (state)
            INIT: begin
                pht_we            = 1'b1;
                init_counter_next = init_counter + 1'b1;
                if (init_counter == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (resolveValid) begin
                    pht_we    = 1'b1;
                    pht_waddr = resolve_idx;
                    if (resolveTaken) begin
                        pht_wdata = (resolve_cnt == 2'b11) ? resolve_cnt : resolve_cnt + 2'b01;
                    end else begin
                        pht_wdata = (resolve_cnt == 2'b00) ? resolve_cnt : resolve_cnt - 2'b01;
                    end
                end
                // Mispredict recovery overrides any speculative shift this cycle.
                if (resolveValid && resolveMispredict) begin
                    spec_ghr_next = {resolveHistory[HISTORY_WIDTH-2:0], resolveTaken};
                end else if (fetchValid && fetchIsBranch) begin
                    spec_ghr_next = {spec_ghr[HISTORY_WIDTH-2:0], predict};
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= INIT;
            init_counter <= '0;
            spec_ghr     <= '0;
        end else begin
            state        <= state_next;
            init_counter <= init_counter_next;
            spec_ghr     <= spec_ghr_next;
        end
    end

    // Counter table has no reset; its contents come only from the init sweep.
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
    end

endmodule

// File: tb/tb_gshare_predictor_ctrl.sv
// Directed bench for gshare_predictor_ctrl: init sweep, counter saturation,
// history shifting, recovery priority, read/write collision and async reset.
module tb_gshare_predictor_ctrl;

    logic        clk;
    logic        rst;
    logic        fetchValid;
    logic        fetchIsBranch;
    logic [31:0] fetchPc;
    logic        isBranchTakenPredicted;
    logic [3:0]  globalBranchHistory;
    logic        predictorReady;
    logic        resolveValid;
    logic [31:0] resolvePc;
    logic [3:0]  resolveHistory;
    logic        resolveTaken;
    logic        resolveMispredict;

    int tests_run;
    int tests_failed;

    gshare_predictor_ctrl #(
        .HISTORY_WIDTH  (4),
        .PHT_INDEX_WIDTH(4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetchValid            (fetchValid),
        .fetchIsBranch         (fetchIsBranch),
        .fetchPc               (fetchPc),
        .isBranchTakenPredicted(isBranchTakenPredicted),
        .globalBranchHistory   (globalBranchHistory),
        .predictorReady        (predictorReady),
        .resolveValid          (resolveValid),
        .resolvePc             (resolvePc),
        .resolveHistory        (resolveHistory),
        .resolveTaken          (resolveTaken),
        .resolveMispredict     (resolveMispredict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve_idle();
        resolveValid      = 1'b0;
        resolveMispredict = 1'b0;
        resolveTaken      = 1'b0;
        resolvePc         = 32'h0;
        resolveHistory    = 4'h0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input int n);
        resolveValid   = 1'b1;
        resolvePc      = pc;
        resolveHistory = 4'h0;
        resolveTaken   = taken;
        for (int k = 0; k < n; k++) step();
        resolve_idle();
    endtask

    initial begin
        logic exp_sat [8];
        logic exp_pred [4];
        logic [3:0] exp_ghr [5];
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b0;
        fetchValid    = 1'b0;
        fetchIsBranch = 1'b0;
        fetchPc       = 32'h0;
        resolve_idle();

        // Reset state
        #2;
        chk("reset_ready", {31'b0, predictorReady}, 32'd0);
        chk("reset_pred", {31'b0, isBranchTakenPredicted}, 32'd0);
        chk("reset_ghr", {28'b0, globalBranchHistory}, 32'd0);

        // Init sweep: 16 cycles not ready, ready from cycle 17
        @(negedge clk);
        rst        = 1'b1;
        fetchValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetchPc = 32'(i * 4);
            #1;
            chk($sformatf("init_ready_c%0d", i + 1), {31'b0, predictorReady}, 32'd0);
            chk($sformatf("init_pred_c%0d", i + 1), {31'b0, isBranchTakenPredicted}, 32'd0);
            chk($sformatf("init_ghr_c%0d", i + 1), {28'b0, globalBranchHistory}, 32'd0);
            step();
        end
        chk("init_ready_c17", {31'b0, predictorReady}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            fetchPc = 32'(i * 4);
            #1;
            chk($sformatf("swept_pred_pc%0h", i * 4), {31'b0, isBranchTakenPredicted}, 32'd0);
        end

        // Saturation on index 2 (pc 0x8, history 0)
        fetchPc = 32'h8;
        #1;
        chk("sat_start", {31'b0, isBranchTakenPredicted}, 32'd0);
        resolveValid   = 1'b1;
        resolvePc      = 32'h8;
        resolveHistory = 4'h0;
        exp_sat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            resolveTaken = (i < 4);
            step();
            chk($sformatf("sat_step%0d", i), {31'b0, isBranchTakenPredicted}, {31'b0, exp_sat[i]});
        end
        // From 00: one taken gives 01 (not taken), second gives 10 (taken)
        resolveTaken = 1'b1;
        step();
        chk("sat_floor_up1", {31'b0, isBranchTakenPredicted}, 32'd0);
        step();
        chk("sat_floor_up2", {31'b0, isBranchTakenPredicted}, 32'd1);
        resolve_idle();

        // Train indices 8, 9, 11, 15 to strongly taken
        train(32'h20, 1'b1, 2);
        train(32'h24, 1'b1, 2);
        train(32'h2C, 1'b1, 2);
        train(32'h3C, 1'b1, 2);

        // History shift with all-taken predictions from fetchPc 0x20
        fetchPc       = 32'h20;
        fetchIsBranch = 1'b1;
        exp_ghr  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("shift_ghr%0d", i), {28'b0, globalBranchHistory}, {28'b0, exp_ghr[i]});
            chk($sformatf("shift_pred%0d", i), {31'b0, isBranchTakenPredicted}, {31'b0, exp_pred[i]});
            step();
        end
        chk("shift_ghr4", {28'b0, globalBranchHistory}, {28'b0, exp_ghr[4]});

        // Recovery beats same-cycle fetch shift
        resolveValid      = 1'b1;
        resolveMispredict = 1'b1;
        resolveHistory    = 4'b1010;
        resolveTaken      = 1'b1;
        resolvePc         = 32'h0;
        step();
        chk("recover_ghr", {28'b0, globalBranchHistory}, 32'h5);

        // Mispredict flag alone does nothing
        resolveValid  = 1'b0;
        fetchIsBranch = 1'b0;
        step();
        chk("mispredict_no_valid", {28'b0, globalBranchHistory}, 32'h5);
        resolve_idle();

        // Read/write collision on index 3 (ghr 0101, pc 0x18 -> idx 3)
        fetchPc        = 32'h18;
        resolveValid   = 1'b1;
        resolvePc      = 32'hC;
        resolveHistory = 4'h0;
        resolveTaken   = 1'b1;
        #1;
        chk("collide_same_cycle", {31'b0, isBranchTakenPredicted}, 32'd0);
        step();
        resolve_idle();
        #1;
        chk("collide_next_cycle", {31'b0, isBranchTakenPredicted}, 32'd1);

        // Load ghr = 1011 via recovery, then async reset between edges
        resolveValid      = 1'b1;
        resolveMispredict = 1'b1;
        resolveHistory    = 4'b0101;
        resolveTaken      = 1'b1;
        step();
        resolve_idle();
        chk("pre_reset_ghr", {28'b0, globalBranchHistory}, 32'hB);
        chk("pre_reset_ready", {31'b0, predictorReady}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ghr", {28'b0, globalBranchHistory}, 32'd0);
        chk("async_ready", {31'b0, predictorReady}, 32'd0);
        chk("async_pred", {31'b0, isBranchTakenPredicted}, 32'd0);

        // Re-init while hammering inputs that INIT must ignore
        @(negedge clk);
        rst               = 1'b1;
        fetchValid        = 1'b1;
        fetchIsBranch     = 1'b1;
        fetchPc           = 32'h20;
        resolveValid      = 1'b1;
        resolveMispredict = 1'b1;
        resolveHistory    = 4'b1111;
        resolveTaken      = 1'b1;
        resolvePc         = 32'h8;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("reinit_ready_c%0d", i + 1), {31'b0, predictorReady}, 32'd0);
            chk($sformatf("reinit_ghr_c%0d", i + 1), {28'b0, globalBranchHistory}, 32'd0);
            step();
        end
        resolve_idle();
        fetchIsBranch = 1'b0;
        #1;
        chk("reinit_ready_c17", {31'b0, predictorReady}, 32'd1);
        chk("reinit_pred_idx8", {31'b0, isBranchTakenPredicted}, 32'd0);
        fetchPc = 32'h8;
        #1;
        chk("reinit_pred_idx2", {31'b0, isBranchTakenPredicted}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
